prbs_checker: RTL and testbench

PRBS-7 (x^7 + x^6 + 1) receive-side checker: the far-end counterpart of the PRBS generator.
- Samples a serial bit stream one bit per valid cycle and self-synchronises to the sequence.
- Declares lock once synchronised, then flags and counts bit errors.
- Sits at the sink of the PRBS link-test path, fed by the generator's serial output or by a channel under test.

---
 rtl/prbs_checker.sv | 157 +++++++++++++++
 tb/tb_prbs_checker.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_checker.sv
// PRBS-7 (x^7 + x^6 + 1) receive checker: self-synchronises to the incoming
// serial stream, declares lock, then flags and counts bit errors.
module prbs_checker #(
    parameter int LOCK_COUNT = 16,
    parameter int LOSS_COUNT = 8,
    parameter int ERR_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 prbs_input,
    input  logic                 in_valid,
    input  logic                 clear_count,
    output logic                 locked,
    output logic                 error_pulse,
    output logic [ERR_WIDTH-1:0] error_count
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [7:0]           LOCK_TGT  = 8'(LOCK_COUNT);
    localparam logic [7:0]           LOSS_TGT  = 8'(LOSS_COUNT);
    localparam logic [ERR_WIDTH-1:0] COUNT_MAX = {ERR_WIDTH{1'b1}};

    // Next sequence bit from the two oldest taps of the window.
    function automatic logic prbs7_tap(input logic [6:0] s);
        return s[6] ^ s[5];
    endfunction

    state_t               state_r, state_nxt_s;
    logic [6:0]           shift_r, shift_nxt_s;
    logic [2:0]           fill_r, fill_nxt_s;
    logic [7:0]           match_r, match_nxt_s, match_inc_s;
    logic [7:0]           miss_r, miss_nxt_s, miss_inc_s;
    logic                 predict_s, mismatch_s;
    logic                 locked_nxt_s, pulse_nxt_s;
    logic [ERR_WIDTH-1:0] count_nxt_s;

    assign predict_s   = prbs7_tap(shift_r);
    assign mismatch_s  = prbs_input ^ predict_s;
    assign match_inc_s = match_r + 8'd1;
    assign miss_inc_s  = miss_r + 8'd1;

    // State and window registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= SEARCH;
            shift_r <= 7'd0;
            fill_r  <= 3'd0;
            match_r <= 8'd0;
            miss_r  <= 8'd0;
        end else begin
            state_r <= state_nxt_s;
            shift_r <= shift_nxt_s;
            fill_r  <= fill_nxt_s;
            match_r <= match_nxt_s;
            miss_r  <= miss_nxt_s;
        end
    end

    // Next-state logic; everything holds while in_valid is low.
    always_comb begin
        state_nxt_s = state_r;
        shift_nxt_s = shift_r;
        fill_nxt_s  = fill_r;
        match_nxt_s = match_r;
        miss_nxt_s  = miss_r;
        if (in_valid) begin
            case (state_r)
                SEARCH: begin
                    shift_nxt_s = {shift_r[5:0], prbs_input};
                    fill_nxt_s  = fill_r + 3'd1;
                    if (fill_r == 3'd6) begin
                        state_nxt_s = VERIFY;
                        match_nxt_s = 8'd0;
                    end else begin
                        state_nxt_s = SEARCH;
                    end
                end
                VERIFY: begin
                    shift_nxt_s = {shift_r[5:0], prbs_input};
                    // An all-zero window predicts zeros forever, so never trust it.
                    if (!mismatch_s && (shift_r != 7'd0)) begin
                        match_nxt_s = match_inc_s;
                        if (match_inc_s == LOCK_TGT) begin
                            state_nxt_s = LOCKED;
                            miss_nxt_s  = 8'd0;
                        end else begin
                            state_nxt_s = VERIFY;
                        end
                    end else begin
                        state_nxt_s = SEARCH;
                        fill_nxt_s  = 3'd0;
                    end
                end
                LOCKED: begin
                    // Free-run on the prediction so a bad bit never enters the window.
                    shift_nxt_s = {shift_r[5:0], predict_s};
                    if (mismatch_s) begin
                        miss_nxt_s = miss_inc_s;
                        if (miss_inc_s == LOSS_TGT) begin
                            state_nxt_s = SEARCH;
                            fill_nxt_s  = 3'd0;
                        end else begin
                            state_nxt_s = LOCKED;
                        end
                    end else begin
                        miss_nxt_s = 8'd0;
                    end
                end
                default: begin
                    state_nxt_s = SEARCH;
                    fill_nxt_s  = 3'd0;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Output next values; clear_count overrides a simultaneous error.
    always_comb begin
        locked_nxt_s = (state_nxt_s == LOCKED);
        pulse_nxt_s  = 1'b0;
        count_nxt_s  = error_count;
        if (clear_count) begin
            pulse_nxt_s = 1'b0;
            count_nxt_s = {ERR_WIDTH{1'b0}};
        end else if (in_valid && (state_r == LOCKED) && mismatch_s) begin
            pulse_nxt_s = 1'b1;
            if (error_count != COUNT_MAX) begin
                count_nxt_s = error_count + ERR_WIDTH'(1'b1);
            end else begin
                count_nxt_s = error_count;
            end
        end else begin
            pulse_nxt_s = 1'b0;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            locked      <= 1'b0;
            error_pulse <= 1'b0;
            error_count <= {ERR_WIDTH{1'b0}};
        end else begin
            locked      <= locked_nxt_s;
            error_pulse <= pulse_nxt_s;
            error_count <= count_nxt_s;
        end
    end

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: a queue-based behavioural model checked every
// cycle, plus literal expectations at the points the scenarios call out.
module tb_prbs_checker;

    localparam int LOCK_COUNT = 16;
    localparam int LOSS_COUNT = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        prbs_input = 1'b0;
    logic        in_valid = 1'b0;
    logic        clear_count = 1'b0;
    logic        locked, error_pulse;
    logic [15:0] error_count;
    logic        locked_sat, error_pulse_sat;
    logic [1:0]  error_count_sat;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    prbs_checker dut (
        .clk(clk), .reset(reset), .prbs_input(prbs_input), .in_valid(in_valid),
        .clear_count(clear_count), .locked(locked), .error_pulse(error_pulse),
        .error_count(error_count)
    );

    prbs_checker #(.ERR_WIDTH(2)) dut_sat (
        .clk(clk), .reset(reset), .prbs_input(prbs_input), .in_valid(in_valid),
        .clear_count(clear_count), .locked(locked_sat), .error_pulse(error_pulse_sat),
        .error_count(error_count_sat)
    );

    // Behavioural model: mode 0 = search, 1 = verify, 2 = locked.
    int m_mode, m_fill, m_matches, m_misses, m_raw;
    bit m_pulse;
    bit m_win[$];
    logic [6:0] gen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        bit pred, zero, b;
        if (!reset) begin
            m_mode = 0; m_fill = 0; m_matches = 0; m_misses = 0; m_raw = 0; m_pulse = 1'b0;
            m_win.delete();
            repeat (7) m_win.push_back(1'b0);
        end else begin
            m_pulse = 1'b0;
            if (in_valid) begin
                b = prbs_input;
                pred = m_win[0] ^ m_win[1];
                zero = 1'b1;
                foreach (m_win[i]) if (m_win[i]) zero = 1'b0;
                if (m_mode == 0) begin
                    m_win.push_back(b);
                    m_fill++;
                    if (m_fill == 7) begin m_mode = 1; m_matches = 0; end
                end else if (m_mode == 1) begin
                    m_win.push_back(b);
                    if (b == pred && !zero) begin
                        m_matches++;
                        if (m_matches == LOCK_COUNT) begin m_mode = 2; m_misses = 0; end
                    end else begin
                        m_mode = 0; m_fill = 0;
                    end
                end else begin
                    m_win.push_back(pred);
                    if (b != pred) begin
                        m_pulse = 1'b1; m_raw++; m_misses++;
                        if (m_misses == LOSS_COUNT) begin m_mode = 0; m_fill = 0; end
                    end else begin
                        m_misses = 0;
                    end
                end
                void'(m_win.pop_front());
            end
            if (clear_count) begin m_raw = 0; m_pulse = 1'b0; end
        end
    endtask

    task automatic step(input bit b, input bit v, input bit c, input bit r);
        @(negedge clk);
        prbs_input = b; in_valid = v; clear_count = c; reset = r;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic next_ref(output bit b);
        b = gen[6] ^ gen[5];
        gen = {gen[5:0], b};
    endtask

    // Every-cycle comparison of both instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("locked", 32'(locked), 32'(m_mode == 2));
                chk("error_pulse", 32'(error_pulse), 32'(m_pulse));
                chk("error_count", 32'(error_count), 32'(m_raw > 65535 ? 65535 : m_raw));
                chk("locked_sat", 32'(locked_sat), 32'(m_mode == 2));
                chk("error_pulse_sat", 32'(error_pulse_sat), 32'(m_pulse));
                chk("error_count_sat", 32'(error_count_sat), 32'(m_raw > 3 ? 3 : m_raw));
            end
        end
    end

    initial begin
        bit b;
        int pulses;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk_en = 1'b1;
        chk("reset_locked", 32'(locked), 32'd0);
        chk("reset_pulse", 32'(error_pulse), 32'd0);
        chk("reset_count", 32'(error_count), 32'd0);

        // Clean lock over two full periods.
        gen = 7'h7F;
        for (int i = 1; i <= 254; i++) begin
            next_ref(b);
            step(b, 1'b1, 1'b0, 1'b1);
            if (i == 22) chk("lock_not_yet", 32'(locked), 32'd0);
            if (i == 23) chk("lock_at_23", 32'(locked), 32'd1);
        end
        chk("clean_count", 32'(error_count), 32'd0);

        // Single inverted bit.
        next_ref(b);
        step(~b, 1'b1, 1'b0, 1'b1);
        chk("single_pulse", 32'(error_pulse), 32'd1);
        chk("single_count", 32'(error_count), 32'd1);
        for (int i = 0; i < 10; i++) begin
            next_ref(b);
            step(b, 1'b1, 1'b0, 1'b1);
        end
        chk("single_after_count", 32'(error_count), 32'd1);
        chk("single_still_locked", 32'(locked), 32'd1);

        // Loss of lock: clear, then every bit wrong.
        next_ref(b);
        step(b, 1'b1, 1'b1, 1'b1);
        chk("clear_count", 32'(error_count), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            next_ref(b);
            step(~b, 1'b1, 1'b0, 1'b1);
            if (i == 7) chk("loss_not_yet", 32'(locked), 32'd1);
        end
        chk("loss_unlocked", 32'(locked), 32'd0);
        chk("loss_pulse", 32'(error_pulse), 32'd1);
        chk("loss_count", 32'(error_count), 32'd8);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 1; i <= 23; i++) begin
            next_ref(b);
            step(b, 1'b1, 1'b0, 1'b1);
            if (i == 22) chk("relock_not_yet", 32'(locked), 32'd0);
        end
        chk("relock", 32'(locked), 32'd1);
        chk("relock_count", 32'(error_count), 32'd8);

        // Reset with valid input, then an all-zero stream.
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("midreset_locked", 32'(locked), 32'd0);
        chk("midreset_count", 32'(error_count), 32'd0);
        for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("zeros_locked", 32'(locked), 32'd0);
        chk("zeros_count", 32'(error_count), 32'd0);

        // Valid gaps 1,0,0 with junk on the idle cycles.
        step(1'b0, 1'b0, 1'b0, 1'b0);
        gen = 7'h7F;
        for (int i = 1; i <= 23; i++) begin
            next_ref(b);
            if (i == 23) chk("gap_lock_not_yet", 32'(locked), 32'd0);
            step(b, 1'b1, 1'b0, 1'b1);
            step(~b, 1'b0, 1'b0, 1'b1);
            step(1'b1, 1'b0, 1'b0, 1'b1);
        end
        chk("gap_locked", 32'(locked), 32'd1);
        for (int k = 0; k < 3; k++) begin
            next_ref(b);
            step(~b, 1'b1, 1'b0, 1'b1);
            next_ref(b);
            step(b, 1'b1, 1'b0, 1'b1);
        end
        chk("three_errors", 32'(error_count), 32'd3);
        next_ref(b);
        step(~b, 1'b1, 1'b1, 1'b1);
        chk("clear_wins_count", 32'(error_count), 32'd0);
        chk("clear_wins_pulse", 32'(error_pulse), 32'd0);
        chk("clear_keeps_lock", 32'(locked), 32'd1);

        // Saturation on the narrow instance.
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            next_ref(b);
            step(~b, 1'b1, 1'b0, 1'b1);
            if (error_pulse_sat) pulses++;
            next_ref(b);
            step(b, 1'b1, 1'b0, 1'b1);
            if (error_pulse_sat) pulses++;
        end
        chk("sat_pulses", 32'(pulses), 32'd5);
        chk("sat_count", 32'(error_count_sat), 32'd3);
        chk("wide_count", 32'(error_count), 32'd5);
        next_ref(b);
        step(~b, 1'b1, 1'b0, 1'b0);
        chk("sat_reset_locked", 32'(locked_sat), 32'd0);
        chk("sat_reset_pulse", 32'(error_pulse_sat), 32'd0);
        chk("sat_reset_count", 32'(error_count_sat), 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("post_reset_search", 32'(locked), 32'd0);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
